// File: rtl/xrv_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight
// and presents the fetched word and its PC to decode, honouring stall and redirect.
module xrv_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        stalling,
   input  logic        flush,
   input  logic        jmp,
   input  logic [31:0] jmp_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic        kill_reg, kill_next;
   logic        pend_reg, pend_next;
   logic [31:0] pend_addr_reg, pend_addr_next;
   logic        if_valid_reg, if_valid_next;
   logic [31:0] if_instr_reg, if_instr_next;
   logic [31:0] if_pc_reg, if_pc_next;
   logic [31:0] jmp_tgt;
   logic        unused_jmp_lsbs;

   assign jmp_tgt         = {jmp_addr[31:2], 2'b00};
   assign unused_jmp_lsbs = ^jmp_addr[1:0];

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      kill_next      = kill_reg;
      pend_next      = pend_reg;
      pend_addr_next = pend_addr_reg;
      if_valid_next  = if_valid_reg;
      if_instr_next  = if_instr_reg;
      if_pc_next     = if_pc_reg;

      case (state_reg)
         S_IDLE: begin
            state_next = S_REQ;
            if (jmp) pc_next = jmp_tgt;
         end
         S_REQ: begin
            // the request cannot be withdrawn, so a redirect is parked and its reply dropped
            if (jmp) begin
               kill_next      = 1'b1;
               pend_next      = 1'b1;
               pend_addr_next = jmp_tgt;
            end
            if (imem_gnt) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_next = S_REQ;
               kill_next  = 1'b0;
               pend_next  = 1'b0;
               if (jmp) begin
                  pc_next = jmp_tgt;
               end else if (kill_reg) begin
                  pc_next = pend_reg ? pend_addr_reg : pc_reg;
               end else if (!flush) begin
                  if_valid_next = 1'b1;
                  if_instr_next = imem_rdata;
                  if_pc_next    = pc_reg;
                  pc_next       = pc_reg + 32'd4;
                  if (stalling) state_next = S_HOLD;
               end
            end else if (jmp) begin
               kill_next      = 1'b1;
               pend_next      = 1'b1;
               pend_addr_next = jmp_tgt;
            end
         end
         S_HOLD: begin
            if (jmp) begin
               pc_next    = jmp_tgt;
               state_next = S_REQ;
            end else if (!stalling) begin
               state_next = S_REQ;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // redirect beats stall: decode must never see the stale word after a jump
      if (jmp || flush) begin
         if_valid_next = 1'b0;
         if_instr_next = NOP_INSTR;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_reg     <= S_IDLE;
         pc_reg        <= RESET_PC_W;
         kill_reg      <= 1'b0;
         pend_reg      <= 1'b0;
         pend_addr_reg <= RESET_PC_W;
         if_valid_reg  <= 1'b0;
         if_instr_reg  <= NOP_INSTR;
         if_pc_reg     <= RESET_PC;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         kill_reg      <= kill_next;
         pend_reg      <= pend_next;
         pend_addr_reg <= pend_addr_next;
         if_valid_reg  <= if_valid_next;
         if_instr_reg  <= if_instr_next;
         if_pc_reg     <= if_pc_next;
      end
   end

   assign imem_req  = (state_reg == S_REQ);
   assign imem_addr = pc_reg;
   assign if_valid  = if_valid_reg;
   assign if_instr  = if_instr_reg;
   assign if_pc     = if_pc_reg;

endmodule
